// File: rtl/mux_arb_nto1_pkg.sv
// mux_defs: selection mode constants shared by the arbitrated mux
package mux_defs;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// rr_arbiter: first requester after the last grant, scanning upward modulo NCH
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] gnt,
  output logic            granted
);
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  int               k;
  int               sum;
  // rotate so bit 0 is channel last+1, then take the lowest set bit
  always_comb begin
    dbl = {req, req} >> (int'(last) + 1);
    rot = dbl[NCH-1:0];
    k = 0;
    for (int i = NCH - 1; i >= 0; i--) k = rot[i] ? i : k;
    sum = int'(last) + 1 + k;
    gnt = SELW'(sum >= NCH ? sum - NCH : sum);
    granted = |req;
  end
endmodule

// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-to-1 valid/ready mux with fixed or round-robin selection and a registered output
import mux_defs::*;
module mux_arb_nto1 #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);
  localparam int NP = 1 << SELW;
  logic [NP-1:0]    vpad;
  logic [SELW-1:0]  last, rr_gnt, gnt;
  logic             rr_ok, granted, load;
  logic [NCH-1:0]   hot;
  logic [WIDTH-1:0] sel_data;
  // zero padding makes any select at or beyond NCH see an idle channel
  assign vpad = NP'(in_valid);
  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_rr (
    .req(in_valid), .last(last), .gnt(rr_gnt), .granted(rr_ok)
  );
  always_comb begin
    gnt = (mode == MODE_RR) ? rr_gnt : sel;
    granted = (mode == MODE_RR) ? rr_ok : vpad[sel];
    load = !out_valid || out_ready;
    for (int c = 0; c < NCH; c++) hot[c] = granted && (gnt == SELW'(c));
    in_ready = (load && !reset) ? hot : '0;
  end
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NCH-1:0] t;
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign t[c] = in_data[c*WIDTH+b] & hot[c];
    end
    assign sel_data[b] = |t;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      last <= SELW'(NCH - 1);
    end else if (load) begin
      out_valid <= granted;
      if (granted) begin
        out_data <= sel_data;
        out_sel <= gnt;
        if (mode == MODE_RR) last <= gnt;
      end
    end
  end
endmodule
